// File: rtl/serv_rf_ram_arb_if.sv
// Signal bundle between the SERV RAM interface, debug port, arbiter and register-file SRAM.
// The arbiter connects through the slave modport; its environment uses master.
interface serv_rf_ram_arb_if #(
  parameter int width = 8,
  parameter int aw    = 8
);
  logic             i_core_rreq;
  logic             i_core_wreq;
  logic             o_core_rreq;
  logic             o_core_wreq;
  logic [aw-1:0]    i_rf_waddr;
  logic [width-1:0] i_rf_wdata;
  logic             i_rf_wen;
  logic [aw-1:0]    i_rf_raddr;
  logic             i_rf_ren;
  logic [width-1:0] o_rf_rdata;
  logic             i_dbg_req;
  logic             i_dbg_we;
  logic [aw-1:0]    i_dbg_addr;
  logic [width-1:0] i_dbg_wdata;
  logic             o_dbg_gnt;
  logic             o_dbg_ack;
  logic [width-1:0] o_dbg_rdata;
  logic [aw-1:0]    o_ram_waddr;
  logic [width-1:0] o_ram_wdata;
  logic             o_ram_wen;
  logic [aw-1:0]    o_ram_raddr;
  logic             o_ram_ren;
  logic [width-1:0] i_ram_rdata;
  logic             o_init_done;
  logic             o_err;

  modport slave (
    input  i_core_rreq, i_core_wreq,
    output o_core_rreq, o_core_wreq,
    input  i_rf_waddr, i_rf_wdata, i_rf_wen, i_rf_raddr, i_rf_ren,
    output o_rf_rdata,
    input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    output o_dbg_gnt, o_dbg_ack, o_dbg_rdata,
    output o_ram_waddr, o_ram_wdata, o_ram_wen, o_ram_raddr, o_ram_ren,
    input  i_ram_rdata,
    output o_init_done, o_err
  );

  modport master (
    output i_core_rreq, i_core_wreq,
    input  o_core_rreq, o_core_wreq,
    output i_rf_waddr, i_rf_wdata, i_rf_wen, i_rf_raddr, i_rf_ren,
    input  o_rf_rdata,
    output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    input  o_dbg_gnt, o_dbg_ack, o_dbg_rdata,
    input  o_ram_waddr, o_ram_wdata, o_ram_wen, o_ram_raddr, o_ram_ren,
    output i_ram_rdata,
    input  o_init_done, o_err
  );
endinterface

// File: rtl/serv_rf_ram_arb.sv
// Shares the register-file SRAM port between SERV bursts, a debug port and a
// post-reset clearing sequencer; core bursts are never interrupted.
module serv_rf_ram_arb #(
  parameter int width      = 8,
  parameter int csr_regs   = 4,
  parameter int aw         = 5 + $clog2(32 + csr_regs) - $clog2(width),
  parameter int CORE_BURST = 40,
  parameter int INIT_EN    = 1
) (
  input logic              i_clk,
  input logic              i_rst,
  serv_rf_ram_arb_if.slave bus
);

  localparam int cw = $clog2(CORE_BURST + 1);
  localparam logic [aw-1:0] LAST_ADDR = '1;
  // The request cycle is the first owned cycle, so the counter only covers the rest.
  localparam logic [cw-1:0] BURST_LOAD = cw'(CORE_BURST - 1);

  typedef enum logic {INIT, RUN} state_t;
  localparam state_t RESET_STATE = (INIT_EN != 0) ? INIT : RUN;

  state_t           state, state_nxt;
  logic [aw-1:0]    init_addr;
  logic [cw-1:0]    cnt;
  logic             pending;
  logic             err;
  logic             ack;
  logic             ack_rd;
  logic [width-1:0] rdata_q;
  logic             core_rreq;
  logic             core_wreq;
  logic             gnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RESET_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    core_rreq       = 1'b0;
    core_wreq       = 1'b0;
    gnt             = 1'b0;
    bus.o_ram_waddr = bus.i_rf_waddr;
    bus.o_ram_wdata = bus.i_rf_wdata;
    bus.o_ram_wen   = bus.i_rf_wen;
    bus.o_ram_raddr = bus.i_rf_raddr;
    bus.o_ram_ren   = bus.i_rf_ren;
    case (state)
      INIT: begin
        bus.o_ram_wen   = 1'b1;
        bus.o_ram_waddr = init_addr;
        bus.o_ram_wdata = '0;
        bus.o_ram_ren   = 1'b0;
        if (init_addr == LAST_ADDR) state_nxt = RUN;
      end
      RUN: begin
        core_rreq = bus.i_core_rreq | pending;
        core_wreq = bus.i_core_wreq;
        gnt = bus.i_dbg_req & (cnt == '0) & ~core_rreq & ~core_wreq;
        if (gnt && bus.i_dbg_we) begin
          bus.o_ram_wen   = 1'b1;
          bus.o_ram_waddr = bus.i_dbg_addr;
          bus.o_ram_wdata = bus.i_dbg_wdata;
          bus.o_ram_ren   = 1'b0;
        end else if (gnt) begin
          bus.o_ram_ren   = 1'b1;
          bus.o_ram_raddr = bus.i_dbg_addr;
          bus.o_ram_wen   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Clearing address, burst ownership, deferred read and debug ack bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      init_addr <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      err       <= 1'b0;
      ack       <= 1'b0;
      ack_rd    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (state == INIT) begin
        init_addr <= init_addr + 1'b1;
        if (bus.i_core_rreq) pending <= 1'b1;
        if (bus.i_core_wreq) err <= 1'b1;
      end else begin
        pending <= 1'b0;
        if (core_rreq || core_wreq) cnt <= BURST_LOAD;
        else if (cnt != '0)         cnt <= cnt - 1'b1;
      end
      ack    <= gnt;
      ack_rd <= gnt & ~bus.i_dbg_we;
      if (ack_rd) rdata_q <= bus.i_ram_rdata;
    end
  end

  // Read data is visible in the ack cycle itself and held until the next read.
  assign bus.o_dbg_rdata = ack_rd ? bus.i_ram_rdata : rdata_q;
  assign bus.o_dbg_gnt   = gnt;
  assign bus.o_dbg_ack   = ack;
  assign bus.o_core_rreq = core_rreq;
  assign bus.o_core_wreq = core_wreq;
  assign bus.o_rf_rdata  = bus.i_ram_rdata;
  assign bus.o_init_done = (state == RUN);
  assign bus.o_err       = err;

endmodule

// File: tb/tb_serv_rf_ram_arb.sv
// Bench for serv_rf_ram_arb: clearing sweep, burst protection, debug accesses
// with a read-data scoreboard, and reset during clearing.
module tb_serv_rf_ram_arb;
  localparam int width = 8;
  localparam int aw    = 8;
  localparam int DEPTH = 256;
  localparam int BURST = 40;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  serv_rf_ram_arb_if #(.width(width), .aw(aw)) bus ();

  serv_rf_ram_arb #(
    .width(width), .csr_regs(4), .CORE_BURST(BURST), .INIT_EN(1)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus(bus)
  );

  typedef struct {
    logic       core_rreq, core_wreq, dbg_req, dbg_we;
    logic [7:0] dbg_addr, dbg_wdata;
    logic       rf_wen, rf_ren;
    logic [7:0] rf_waddr, rf_wdata, rf_raddr;
    logic [5:0] x_ctl;
    logic [7:0] x_waddr, x_wdata, x_raddr;
  } vec_t;

  typedef struct packed {
    logic             is_read;
    logic [width-1:0] data;
  } sb_t;

  int n_checks = 0;
  int n_fail   = 0;
  sb_t sb_q[$];
  sb_t sb_e;
  logic [width-1:0] last_rd = '0;
  logic [width-1:0] shadow[DEPTH];
  logic [width-1:0] mem[DEPTH];
  logic preload;
  vec_t vecs[5];
  vec_t v;
  logic [7:0] ra, rd, rr;
  logic [1:0] re;
  int nz;

  // SRAM model with one-cycle read latency; preload fills it with non-zero junk.
  always @(posedge i_clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
      bus.i_ram_rdata <= '0;
    end else begin
      if (bus.o_ram_wen) mem[bus.o_ram_waddr] <= bus.o_ram_wdata;
      if (bus.o_ram_ren) bus.i_ram_rdata <= mem[bus.o_ram_raddr];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t row(input logic [3:0] ctl, input logic [7:0] da, dw,
                               input logic [1:0] rfen, input logic [7:0] rwa, rwd, rra,
                               input logic [5:0] xctl, input logic [7:0] xwa, xwd, xra);
    vec_t r;
    {r.core_rreq, r.core_wreq, r.dbg_req, r.dbg_we} = ctl;
    r.dbg_addr = da;  r.dbg_wdata = dw;
    {r.rf_wen, r.rf_ren} = rfen;
    r.rf_waddr = rwa; r.rf_wdata = rwd; r.rf_raddr = rra;
    r.x_ctl = xctl;   r.x_waddr = xwa;  r.x_wdata = xwd; r.x_raddr = xra;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t s);
    bus.i_core_rreq = s.core_rreq;
    bus.i_core_wreq = s.core_wreq;
    bus.i_dbg_req   = s.dbg_req;
    bus.i_dbg_we    = s.dbg_we;
    bus.i_dbg_addr  = s.dbg_addr;
    bus.i_dbg_wdata = s.dbg_wdata;
    bus.i_rf_wen    = s.rf_wen;
    bus.i_rf_ren    = s.rf_ren;
    bus.i_rf_waddr  = s.rf_waddr;
    bus.i_rf_wdata  = s.rf_wdata;
    bus.i_rf_raddr  = s.rf_raddr;
  endtask

  task automatic nextCycle();
    @(posedge i_clk);
    #1;
  endtask

  // Debug acks are matched in order against the expectations queued at grant time.
  always @(negedge i_clk) begin
    if (!i_rst && bus.o_dbg_ack) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected dbg ack", 64'd1, 64'd0);
      end else begin
        sb_e = sb_q.pop_front();
        if (sb_e.is_read) begin
          checkOutput("dbg read data", bus.o_dbg_rdata, sb_e.data);
          last_rd = sb_e.data;
        end else begin
          checkOutput("dbg write keeps rdata", bus.o_dbg_rdata, last_rd);
        end
      end
    end
  end

  initial begin
    vecs[0] = row(4'b0011, 8'h12, 8'hA5, 2'b00, 8'h00, 8'h00, 8'h00, 6'b001110, 8'h12, 8'hA5, 8'h00);
    vecs[1] = row(4'b0010, 8'h12, 8'h00, 2'b00, 8'h00, 8'h00, 8'h00, 6'b001101, 8'h00, 8'h00, 8'h12);
    vecs[2] = row(4'b1000, 8'h00, 8'h00, 2'b11, 8'h20, 8'h5C, 8'h21, 6'b100111, 8'h20, 8'h5C, 8'h21);
    vecs[3] = row(4'b0111, 8'h30, 8'h77, 2'b00, 8'h00, 8'h00, 8'h00, 6'b010000, 8'h00, 8'h00, 8'h00);
    vecs[4] = row(4'b0011, 8'h30, 8'h77, 2'b01, 8'h00, 8'h00, 8'h44, 6'b000001, 8'h00, 8'h00, 8'h44);
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

    i_rst = 1'b1;
    preload = 1'b1;
    applyStimulus(row(4'b0000, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    nextCycle();
    nextCycle();
    preload = 1'b0;
    checkOutput("reset state {ack,rdata,err,done}",
                {bus.o_dbg_ack, bus.o_dbg_rdata, bus.o_err, bus.o_init_done}, 11'd0);
    i_rst = 1'b0;

    // Clearing sweep with a core read at cycle 10 and a debug read held throughout.
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(row({k == 10, 1'b0, 1'b1, 1'b0}, 8'h03, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      #1;
      checkOutput($sformatf("init cycle %0d", k),
                  {bus.o_core_rreq, bus.o_dbg_gnt, bus.o_ram_wen, bus.o_ram_ren, bus.o_init_done,
                   bus.o_err, bus.o_ram_waddr, bus.o_ram_wdata}, {6'b001000, 8'(k), 8'h00});
      nextCycle();
    end
    applyStimulus(row(4'b0010, 8'h03, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("first RUN cycle {rreq,gnt,done}",
                {bus.o_core_rreq, bus.o_dbg_gnt, bus.o_init_done}, 3'b101);
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] != '0) nz++;
    checkOutput("sram cleared nonzero count", nz, 0);
    nextCycle();

    // Deferred read owns the port; the debug read must wait out the burst.
    for (int k = 1; k <= BURST; k++) begin
      re = {k[0], k[1]};
      ra = 8'(k); rd = ~8'(k); rr = 8'(k + 1);
      applyStimulus(row(4'b0010, 8'h03, 0, re, ra, rd, rr, 0, 0, 0, 0));
      #1;
      if (k < BURST) begin
        checkOutput($sformatf("burst passthrough %0d", k),
                    {bus.o_core_rreq, bus.o_dbg_gnt, bus.o_ram_wen, bus.o_ram_ren,
                     bus.o_ram_waddr, bus.o_ram_wdata, bus.o_ram_raddr}, {2'b00, re, ra, rd, rr});
        if (re[1]) shadow[ra] = rd;
      end else begin
        checkOutput("dbg read grant after burst",
                    {bus.o_core_rreq, bus.o_dbg_gnt, bus.o_ram_wen, bus.o_ram_ren, bus.o_ram_raddr},
                    {4'b0101, 8'h03});
        sb_q.push_back({1'b1, shadow[3]});
      end
      nextCycle();
    end

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      applyStimulus(v);
      #1;
      checkOutput($sformatf("table row %0d", i),
                  {bus.o_core_rreq, bus.o_core_wreq, bus.o_dbg_gnt, bus.o_dbg_ack, bus.o_ram_wen,
                   bus.o_ram_ren, bus.o_ram_waddr, bus.o_ram_wdata, bus.o_ram_raddr},
                  {v.x_ctl, v.x_waddr, v.x_wdata, v.x_raddr});
      if (v.x_ctl[3] && v.dbg_we) begin
        shadow[v.dbg_addr] = v.dbg_wdata;
        sb_q.push_back({1'b0, 8'h00});
      end else if (v.x_ctl[3]) begin
        sb_q.push_back({1'b1, shadow[v.dbg_addr]});
      end else if (v.rf_wen) begin
        shadow[v.rf_waddr] = v.rf_wdata;
      end
      nextCycle();
    end

    // The wreq in row 3 reloaded the burst, so the held debug write lands 40 cycles later.
    for (int j = 2; j <= BURST; j++) begin
      re = 2'($urandom); ra = 8'($urandom); rd = 8'($urandom); rr = 8'($urandom);
      applyStimulus(row(4'b0011, 8'h30, 8'h77, re, ra, rd, rr, 0, 0, 0, 0));
      #1;
      if (j < BURST) begin
        checkOutput($sformatf("wreq burst passthrough %0d", j),
                    {bus.o_dbg_gnt, bus.o_dbg_ack, bus.o_ram_wen, bus.o_ram_ren,
                     bus.o_ram_waddr, bus.o_ram_wdata, bus.o_ram_raddr}, {2'b00, re, ra, rd, rr});
        if (re[1]) shadow[ra] = rd;
      end else begin
        checkOutput("dbg write grant after reload",
                    {bus.o_dbg_gnt, bus.o_ram_wen, bus.o_ram_ren, bus.o_ram_waddr, bus.o_ram_wdata},
                    {3'b110, 8'h30, 8'h77});
        shadow[8'h30] = 8'h77;
        sb_q.push_back({1'b0, 8'h00});
      end
      nextCycle();
    end
    applyStimulus(row(4'b0010, 8'h30, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("dbg read 0x30 grant",
                {bus.o_dbg_gnt, bus.o_ram_ren, bus.o_ram_wen, bus.o_ram_raddr}, {3'b110, 8'h30});
    sb_q.push_back({1'b1, shadow[8'h30]});
    nextCycle();
    applyStimulus(row(4'b0000, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("idle after read {gnt,ack}", {bus.o_dbg_gnt, bus.o_dbg_ack}, 2'b01);
    nextCycle();
    nextCycle();

    // Core write during clearing, then reset in the middle of the sweep.
    i_rst = 1'b1;
    nextCycle();
    i_rst = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      applyStimulus(row({1'b0, k == 50, 2'b00}, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      if (k == 100) i_rst = 1'b1;
      #1;
      if (k == 50)
        checkOutput("wreq in init {wreq,err}", {bus.o_core_wreq, bus.o_err}, 2'b00);
      if (k == 51 || k == 100)
        checkOutput($sformatf("err sticky cycle %0d", k), {bus.o_err, bus.o_ram_waddr}, {1'b1, 8'(k)});
      nextCycle();
    end
    i_rst = 1'b0;
    #1;
    checkOutput("restart after reset {wen,waddr,wdata,done,err,ack}",
                {bus.o_ram_wen, bus.o_ram_waddr, bus.o_ram_wdata, bus.o_init_done, bus.o_err,
                 bus.o_dbg_ack}, {1'b1, 8'h00, 8'h00, 3'b000});
    nextCycle();
    checkOutput("second clear address", bus.o_ram_waddr, 8'h01);
    checkOutput("scoreboard drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
